// File: rtl/conf_merge_rr_arb.sv
// ============================================================================
// Module   : conf_merge_rr_arb
// Purpose  : Clocked N-way round-robin arbiter. It merges N_REQ drive/free
//            handshake channels onto one downstream channel and one
//            registered data bus. The granted requester's data is captured
//            into o_data on the same edge that raises o_driveNext, so o_data
//            stays stable for the whole transfer.
// Options  : CONF_MERGE_RR_ARB_TIMEOUT_EN - adds a WAIT-state watchdog and
//            the sticky o_timeout output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conf_merge_rr_arb #(
  parameter int N_REQ          = 2,
  parameter int DATA_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            i_drive,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_data,
  output logic [N_REQ-1:0]            o_free,
  output logic                        o_driveNext,
  output logic [DATA_WIDTH-1:0]       o_data,
  input  logic                        i_freeNext,
  output logic [N_REQ-1:0]            o_grant,
  output logic                        o_busy,
  output logic                        o_err
`ifdef CONF_MERGE_RR_ARB_TIMEOUT_EN
  ,
  output logic                        o_timeout
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  // Reject configurations outside the supported range at elaboration time.
  if ((N_REQ < 1) || (N_REQ > 8) || (DATA_WIDTH < 1) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("conf_merge_rr_arb: unsupported parameter value");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    FREE  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;

  logic [N_REQ-1:0]       pending;
  logic [N_REQ-1:0]       pending_set;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       cur_idx;

  logic                   found;
  logic [IDX_W-1:0]       pick;
  logic [IDX_W-1:0]       cand;
  logic [N_REQ-1:0]       pick_onehot;
  logic [N_REQ-1:0]       in_flight;

  logic                   do_grant;
  logic                   do_free;
  logic                   err_set;

  logic [DATA_WIDTH-1:0]  data_arr [N_REQ];

  // Unpack the flattened requester data bus into one word per requester.
  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign data_arr[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef CONF_MERGE_RR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0]       wait_cnt;
  logic                   timeout_hit;
`endif

  assign o_busy = (state != IDLE);

  // The requester whose transfer is still open (DRIVE/WAIT/FREE) must not
  // be re-queued by a premature drive pulse.
  assign in_flight   = (state != IDLE) ? o_grant : '0;
  assign pending_set = i_drive & ~in_flight;

  // Round-robin pick: first pending bit at or above rr_ptr, with wrap.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    cand  = rr_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % N_REQ);
      if (!found && pending[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    pick_onehot       = '0;
    pick_onehot[pick] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and per-edge transfer strobes.
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_free   = 1'b0;
`ifdef CONF_MERGE_RR_ARB_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          do_grant  = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (i_freeNext) begin
          do_free   = 1'b1;
          state_nxt = FREE;
        end
`ifdef CONF_MERGE_RR_ARB_TIMEOUT_EN
        else if (wait_cnt == CNT_LIMIT) begin
          do_free     = 1'b1;
          timeout_hit = 1'b1;
          state_nxt   = FREE;
        end
`endif
      end
      FREE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Protocol-violation detection: duplicate drive, drive of the requester
  // being granted on this edge, drive while in flight, stray completion.
  always_comb begin
    err_set = i_freeNext && (state != WAIT);
    if (|(i_drive & pending)) begin
      err_set = 1'b1;
    end
    if (|(i_drive & in_flight)) begin
      err_set = 1'b1;
    end
    if (do_grant && |(i_drive & pick_onehot)) begin
      err_set = 1'b1;
    end
  end

  // Pending set, grant capture, downstream strobes and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending     <= '0;
      rr_ptr      <= '0;
      cur_idx     <= '0;
      o_data      <= '0;
      o_grant     <= '0;
      o_driveNext <= 1'b0;
      o_free      <= '0;
      o_err       <= 1'b0;
    end else begin
      // A new drive wins over the clear of the bit being granted.
      pending <= (pending & ~(do_grant ? pick_onehot : '0)) | pending_set;

      if (do_grant) begin
        o_data  <= data_arr[pick];
        o_grant <= pick_onehot;
        cur_idx <= pick;
      end else if (state == FREE) begin
        o_grant <= '0;
      end

      o_driveNext <= do_grant;
      o_free      <= do_free ? o_grant : '0;

      if (do_free) begin
        rr_ptr <= (cur_idx == LAST_IDX) ? '0 : cur_idx + 1'b1;
      end

      if (err_set) begin
        o_err <= 1'b1;
      end
    end
  end

`ifdef CONF_MERGE_RR_ARB_TIMEOUT_EN
  // Watchdog: counts edges spent in WAIT, cleared in every other state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      o_timeout <= 1'b0;
    end else begin
      if (state != WAIT) begin
        wait_cnt <= '0;
      end else if (wait_cnt != CNT_LIMIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout_hit) begin
        o_timeout <= 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_conf_merge_rr_arb.sv
// ============================================================================
// Module   : tb_conf_merge_rr_arb
// Purpose  : Scoreboard bench for conf_merge_rr_arb (N_REQ=4, 16-bit data).
//            Directed stimulus pushes expected transfers and completions;
//            a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conf_merge_rr_arb;

  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk;
  logic            rst;
  logic [N-1:0]    i_drive;
  logic [N*DW-1:0] i_data;
  logic [N-1:0]    o_free;
  logic            o_driveNext;
  logic [DW-1:0]   o_data;
  logic            i_freeNext;
  logic [N-1:0]    o_grant;
  logic            o_busy;
  logic            o_err;
`ifdef CONF_MERGE_RR_ARB_TIMEOUT_EN
  logic            o_timeout;
`endif

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } xfer_t;

  xfer_t exp_q[$];
  int    free_q[$];
  int    total = 0;
  int    bad   = 0;

  conf_merge_rr_arb #(
    .N_REQ         (N),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_drive    (i_drive),
    .i_data     (i_data),
    .o_free     (o_free),
    .o_driveNext(o_driveNext),
    .o_data     (o_data),
    .i_freeNext (i_freeNext),
    .o_grant    (o_grant),
    .o_busy     (o_busy),
    .o_err      (o_err)
`ifdef CONF_MERGE_RR_ARB_TIMEOUT_EN
    ,
    .o_timeout  (o_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [DW-1:0] v);
    i_data[k*DW +: DW] = v;
  endtask

  task automatic pulse_drive(input logic [N-1:0] m);
    i_drive = m;
    tick();
    i_drive = '0;
  endtask

  task automatic pulse_free();
    i_freeNext = 1'b1;
    tick();
    i_freeNext = 1'b0;
  endtask

  task automatic push(input int k, input logic [DW-1:0] d, input bit with_free);
    xfer_t x;
    x.idx  = k;
    x.data = d;
    exp_q.push_back(x);
    if (with_free) free_q.push_back(k);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Wait (bounded) for a downstream drive, then complete it two cycles
  // later and return in the following IDLE cycle.
  task automatic serve();
    int n;
    n = 0;
    while (o_driveNext !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL serve_wait: got no drive within %0d cycles expected a drive", n);
    end
    tick();
    tick();
    pulse_free();
    tick();
  endtask

  // Monitor: compare every downstream drive and every completion pulse.
  initial begin
    xfer_t x;
    int    k;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (o_driveNext === 1'b1) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_drive: got grant %b data %h expected none", o_grant, o_data);
          end else begin
            x = exp_q.pop_front();
            check("xfer_data", 32'(o_data), 32'(x.data));
            check("xfer_grant", 32'(o_grant), 32'(1) << x.idx);
          end
        end
        if (o_free !== '0) begin
          if (free_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_free: got %b expected none", o_free);
          end else begin
            k = free_q.pop_front();
            check("free_pulse", 32'(o_free), 32'(1) << k);
          end
        end
      end
    end
  end

  // Absolute time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    rst        = 1'b0;
    i_drive    = '0;
    i_data     = '0;
    i_freeNext = 1'b0;
    #1;
    // Reset values
    check("rst_drive", 32'(o_driveNext), 32'd0);
    check("rst_free", 32'(o_free), 32'd0);
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Single request with latency checks
    set_data(0, 16'hA5A5);
    push(0, 16'hA5A5, 1'b1);
    pulse_drive(4'b0001);
    check("single_no_early_drive", 32'(o_driveNext), 32'd0);
    tick();
    check("single_drive", 32'(o_driveNext), 32'd1);
    check("single_data", 32'(o_data), 32'hA5A5);
    check("single_grant", 32'(o_grant), 32'b0001);
    check("single_busy", 32'(o_busy), 32'd1);
    tick();
    check("single_drive_one_cycle", 32'(o_driveNext), 32'd0);
    tick();
    pulse_free();
    check("single_free", 32'(o_free), 32'b0001);
    tick();
    check("single_free_clear", 32'(o_free), 32'd0);
    check("single_grant_clear", 32'(o_grant), 32'd0);
    check("single_idle", 32'(o_busy), 32'd0);

    // Collision of requesters 0 and 1
    do_reset();
    set_data(0, 16'h0011);
    set_data(1, 16'h0022);
    push(0, 16'h0011, 1'b1);
    push(1, 16'h0022, 1'b1);
    pulse_drive(4'b0011);
    serve();
    serve();
    check("collision_err", 32'(o_err), 32'd0);

    // Fairness: all four requesters, each re-issued after its completion
    do_reset();
    for (int k = 0; k < N; k++) begin
      set_data(k, 16'hC000 | 16'(k));
      push(k, 16'hC000 | 16'(k), 1'b1);
    end
    for (int k = 0; k < N; k++) begin
      push(k, 16'hD000 | 16'(k), 1'b1);
    end
    pulse_drive(4'b1111);
    for (int r = 0; r < 8; r++) begin
      serve();
      if (r < N) begin
        set_data(r, 16'hD000 | 16'(r));
        pulse_drive(4'(1 << r));
      end
    end
    check("fair_err", 32'(o_err), 32'd0);

    // Violation: repeat drive[1] while requester 1 is in flight
    do_reset();
    set_data(1, 16'h0033);
    push(1, 16'h0033, 1'b1);
    pulse_drive(4'b0010);
    tick();
    pulse_drive(4'b0010);
    check("viol_inflight_err", 32'(o_err), 32'd1);
    tick();
    pulse_free();
    tick();
    repeat (8) tick();
    check("viol_err_sticky", 32'(o_err), 32'd1);
    check("viol_idle", 32'(o_busy), 32'd0);

    // Violation: stray i_freeNext in IDLE
    do_reset();
    check("viol_err_cleared", 32'(o_err), 32'd0);
    pulse_free();
    check("viol_free_idle_err", 32'(o_err), 32'd1);
    check("viol_free_idle_busy", 32'(o_busy), 32'd0);

    // Reset while in WAIT with requester 1 still pending
    do_reset();
    set_data(0, 16'h0044);
    set_data(1, 16'h0055);
    push(0, 16'h0044, 1'b0);
    pulse_drive(4'b0011);
    tick();
    tick();
    check("wait_busy_before_rst", 32'(o_busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_busy", 32'(o_busy), 32'd0);
    check("async_rst_grant", 32'(o_grant), 32'd0);
    check("async_rst_data", 32'(o_data), 32'd0);
    check("async_rst_free", 32'(o_free), 32'd0);
    check("async_rst_drive", 32'(o_driveNext), 32'd0);
    #3;
    rst = 1'b1;
    repeat (10) tick();
    check("post_rst_idle", 32'(o_busy), 32'd0);

`ifdef CONF_MERGE_RR_ARB_TIMEOUT_EN
    // Watchdog: no completion, FREE forced 17 edges after entering WAIT
    do_reset();
    set_data(2, 16'h0066);
    push(2, 16'h0066, 1'b1);
    pulse_drive(4'b0100);
    tick();
    check("to_drive", 32'(o_driveNext), 32'd1);
    repeat (17) tick();
    check("to_not_yet_free", 32'(o_free), 32'd0);
    check("to_not_yet_flag", 32'(o_timeout), 32'd0);
    tick();
    check("to_free", 32'(o_free), 32'b0100);
    check("to_flag", 32'(o_timeout), 32'd1);
    tick();
    check("to_idle", 32'(o_busy), 32'd0);
`endif

    repeat (5) tick();
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    check("free_queue_empty", 32'(free_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/conf_merge_rr_arb.md
Name: conf_merge_rr_arb

Overview:
- Clocked N-way round-robin arbiter that shares one downstream drive/free channel and one registered data bus between N_REQ upstream requesters.
- Replaces the mutex-merge element wherever requesters may collide.
- Sits between producer stages and a single consumer stage.
- Captures the granted requester's data into an output register before issuing the downstream drive, so o_data is stable for the whole transfer.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- DATA_WIDTH, 128, width of each data word
- TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles; used only with the optional feature

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset (decided: one clock; reset async, active-low)
- i_drive  in  N_REQ  per-requester request pulse, one clk wide
- i_data  in  N_REQ*DATA_WIDTH  requester data, flattened; slice k = [k*DATA_WIDTH +: DATA_WIDTH]
- o_free  out  N_REQ  per-requester completion pulse, one clk wide
- o_driveNext  out  1  downstream drive pulse, one clk wide
- o_data  out  DATA_WIDTH  registered merged data
- i_freeNext  in  1  downstream completion pulse
- o_grant  out  N_REQ  one-hot of the requester in flight; 0 when idle
- o_busy  out  1  high in any state other than IDLE
- o_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE; pending=0; rr_ptr=0.
  - o_data=0, o_free=0, o_driveNext=0, o_grant=0, o_busy=0, o_err=0.
- Request protocol:
  - A requester raises i_drive[k] for one cycle.
  - It holds i_data slice k stable until it sees o_free[k].
  - It must not pulse i_drive[k] again before that o_free[k].
- Pending capture:
  - i_drive[k]=1 at a rising edge sets pending[k].
- FSM states: IDLE, DRIVE, WAIT, FREE.
- IDLE:
  - If pending!=0 at an edge, choose the grant g = first set pending bit, scanning from rr_ptr upward with wrap-around modulo N_REQ.
  - On that same edge: o_data <= slice g; pending[g] cleared; o_grant <= onehot(g); o_driveNext <= 1; next state DRIVE.
- DRIVE:
  - o_driveNext is high exactly this one cycle; it is deasserted on the next edge.
  - Next state WAIT.
- WAIT:
  - Hold o_data and o_grant.
  - On an edge with i_freeNext=1: o_free[g] <= 1; rr_ptr <= (g+1) mod N_REQ; next state FREE.
- FREE:
  - o_free[g] is high this one cycle.
  - On the next edge: o_free <= 0; o_grant <= 0; next state IDLE.
- Latency:
  - i_drive sampled at edge E gives o_driveNext high in the cycle after edge E+1.
  - i_freeNext sampled at edge F gives o_free high in the cycle after F.
  - Minimum request-to-request spacing on the downstream channel is 4 cycles.
- Simultaneous drives: all are latched into pending and served in round-robin order. No request is ever dropped.
- i_drive[k] at the same edge as the grant of k:
  - This is a protocol violation.
  - pending[k] ends up set (the set wins over the clear), and o_err <= 1.
- i_drive[k] while pending[k]=1, or while k is in flight (state!=IDLE and o_grant[k]=1):
  - o_err <= 1.
  - The pending bit stays at 1, so no duplicate is queued.
- i_freeNext outside WAIT: ignored; o_err <= 1.
- o_err clears only on reset.
- Reset mid-transfer: everything returns to reset values immediately. In-flight and pending requests are discarded, and no o_free is issued for them.
- N_REQ=1 degenerates to a pass-through sequencer with rr_ptr fixed at 0.

Optional Feature:
- Macro CONF_MERGE_RR_ARB_TIMEOUT_EN.
- When defined:
  - A counter of at least clog2(TIMEOUT_CYCLES+1) bits runs in WAIT and is cleared on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES without i_freeNext, the FSM goes to FREE: o_free[g] pulses normally, and a sticky output o_timeout (extra 1-bit port, reset 0) is set.
  - rr_ptr advances as for a normal completion.
- When not defined:
  - The o_timeout port and the counter do not exist.
  - WAIT waits indefinitely.

Test Plan:
- Single request: drive[0] pulse with data0=0xA5A5 -> o_data=0xA5A5 and o_driveNext high 2 cycles later; i_freeNext 3 cycles after that -> o_free[0] 1 cycle later; o_grant returns to 0.
- Collision: drive[0] and drive[1] on the same edge, data 0x11 / 0x22 -> transfers in order 0x11 then 0x22; o_free[0] precedes o_free[1]; o_err=0.
- Fairness: N_REQ=4, drive[0..3] held as repeated pulses re-issued after each o_free -> grant order 0,1,2,3,0,1 and no requester starves.
- Violations: a second drive[1] while 1 is in flight, and an i_freeNext pulse in IDLE -> o_err=1 each time; exactly one transfer is produced for requester 1.
- Reset in WAIT: assert rst low mid-transfer with pending[1] set -> all outputs 0 asynchronously; after release, no o_driveNext until a new drive.
- With CONF_MERGE_RR_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: grant, then no i_freeNext -> o_free[g] 17 cycles after entering WAIT (counter reaches 16 at the 16th edge, FREE one edge later); o_timeout=1.
